// File: rtl/sap1_program_loader.sv
// rtl/sap1_program_loader.sv - streams a program into SAP-1 RAM, then runs the CPU and watches for halt
//
// Ports:
//   clk        rising-edge clock shared with the CPU
//   n_clr      asynchronous active-low reset of the loader
//   start      one-cycle pulse; begins a load from IDLE, DONE or FAULT
//   abort      synchronous return to IDLE; overrides every other input
//   in_valid   program byte available on in_data
//   in_data    program byte
//   in_ready   loader accepts a byte (high only while waiting for one)
//   n_hlt      CPU halt line, low = halted
//   ch_s2      CPU run/load switch (0 = load, 1 = execute)
//   ch_s4      RAM write switch, active low
//   a, d       RAM address and data during load
//   cpu_n_clr  active-low clear to the CPU
//   busy       high while loading, clearing or running
//   done       CPU halted normally (sticky until start/abort)
//   timeout    run cycle limit expired (sticky until start/abort)
module sap1_program_loader #(
  parameter int PROG_LEN    = 16,
  parameter int WE_CYCLES   = 2,
  parameter int CLR_CYCLES  = 4,
  parameter int RUN_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       n_clr,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       n_hlt,
  output logic       ch_s2,
  output logic       ch_s4,
  output logic [3:0] a,
  output logic [7:0] d,
  output logic       cpu_n_clr,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  // One phase counter serves both the write pulse and the CPU clear pulse.
  localparam int PH_MAX = (WE_CYCLES > CLR_CYCLES) ? WE_CYCLES : CLR_CYCLES;
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
  localparam int RUN_W  = (RUN_TIMEOUT < 3) ? 1 : $clog2(RUN_TIMEOUT);

  localparam logic [PH_W-1:0]  WE_LAST  = PH_W'(WE_CYCLES - 1);
  localparam logic [PH_W-1:0]  CLR_LAST = PH_W'(CLR_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'((RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0);
  localparam logic [4:0]       LEN5     = 5'(PROG_LEN);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_CLEAR,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state;
  logic [4:0]       addr_cnt;   // 5 bits so it can reach 16 without wrapping
  logic [PH_W-1:0]  phase_cnt;
  logic [RUN_W-1:0] run_cnt;    // holds (RUN cycle number - 1)
  logic [4:0]       addr_inc;

  assign addr_inc = addr_cnt + 5'd1;

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      state     <= S_IDLE;
      addr_cnt  <= 5'd0;
      phase_cnt <= '0;
      run_cnt   <= '0;
      ch_s2     <= 1'b0;
      ch_s4     <= 1'b1;
      a         <= 4'd0;
      d         <= 8'd0;
      cpu_n_clr <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else if (abort) begin
      // a and d are left as they were; the write strobe is what matters.
      state     <= S_IDLE;
      phase_cnt <= '0;
      run_cnt   <= '0;
      ch_s2     <= 1'b0;
      ch_s4     <= 1'b1;
      cpu_n_clr <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            state     <= S_WAIT_BYTE;
            addr_cnt  <= 5'd0;
            ch_s2     <= 1'b0;
            ch_s4     <= 1'b1;
            cpu_n_clr <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
          end
        end

        S_WAIT_BYTE: begin
          if (in_valid && in_ready) begin
            state    <= S_SETUP;
            a        <= addr_cnt[3:0];
            d        <= in_data;
            in_ready <= 1'b0;
          end
        end

        // Address/data already settled on a and d for one cycle.
        S_SETUP: begin
          state     <= S_WRITE;
          phase_cnt <= '0;
          ch_s4     <= 1'b0;
        end

        S_WRITE: begin
          if (phase_cnt == WE_LAST) begin
            state <= S_HOLD;
            ch_s4 <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        // Write strobe released while a and d stay put.
        S_HOLD: begin
          addr_cnt <= addr_inc;
          if (addr_inc == LEN5) begin
            state     <= S_CLEAR;
            phase_cnt <= '0;
            ch_s2     <= 1'b1;
            cpu_n_clr <= 1'b0;
          end else begin
            state    <= S_WAIT_BYTE;
            in_ready <= 1'b1;
          end
        end

        // CPU sees execute mode while still held in clear; n_hlt is ignored.
        S_CLEAR: begin
          if (phase_cnt == CLR_LAST) begin
            state     <= S_RUN;
            run_cnt   <= '0;
            cpu_n_clr <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        // Halt is checked first so it wins over a same-cycle timeout.
        S_RUN: begin
          if (!n_hlt) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if ((RUN_TIMEOUT != 0) && (run_cnt == RUN_LAST)) begin
            state     <= S_FAULT;
            timeout   <= 1'b1;
            busy      <= 1'b0;
            cpu_n_clr <= 1'b0;
            ch_s2     <= 1'b0;
          end else if (RUN_TIMEOUT != 0) begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          ch_s2     <= 1'b0;
          ch_s4     <= 1'b1;
          cpu_n_clr <= 1'b0;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_program_loader.sv
// tb/tb_sap1_program_loader.sv - self-checking bench for sap1_program_loader
module tb_sap1_program_loader;

  localparam int PROG_LEN    = 16;
  localparam int WE_CYCLES   = 2;
  localparam int CLR_CYCLES  = 4;
  localparam int RUN_TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       n_clr = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       n_hlt = 1'b1;
  logic       in_ready;
  logic       ch_s2;
  logic       ch_s4;
  logic [3:0] a;
  logic [7:0] d;
  logic       cpu_n_clr;
  logic       busy;
  logic       done;
  logic       timeout;

  sap1_program_loader #(
    .PROG_LEN(PROG_LEN), .WE_CYCLES(WE_CYCLES),
    .CLR_CYCLES(CLR_CYCLES), .RUN_TIMEOUT(RUN_TIMEOUT)
  ) dut (
    .clk(clk), .n_clr(n_clr), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .n_hlt(n_hlt), .ch_s2(ch_s2), .ch_s4(ch_s4), .a(a), .d(d),
    .cpu_n_clr(cpu_n_clr), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors = 0;
  int          cycle = 0;
  int          accepted = 0;
  int          low_len = 0;
  bit          loading = 0;
  bit          just_xfer = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_push = '0;
  logic [3:0]  wa = '0;
  logic [7:0]  wd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cycle);
    end
  endtask

  // Advance one clock, sample on the falling edge and track RAM writes.
  task automatic cyc();
    logic [11:0] e;
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (in_ready) chk("ready_window", 32'(loading && (accepted <= PROG_LEN) && exp_q.size() == 0), 1);
    if (just_xfer) begin
      chk("setup_ready", 32'(in_ready), 0);
      chk("setup_we", 32'(ch_s4), 1);
      chk("setup_ad", 32'({a, d}), 32'(last_push));
      just_xfer = 0;
    end
    if (ch_s4 === 1'b0) begin
      chk("we_ready", 32'(in_ready), 0);
      if (low_len == 0) begin
        wa = a;
        wd = d;
      end else begin
        chk("we_stable", 32'({a, d}), 32'({wa, wd}));
      end
      low_len++;
    end else if (low_len > 0) begin
      chk("we_len", 32'(low_len), WE_CYCLES);
      chk("hold_ad", 32'({a, d}), 32'({wa, wd}));
      chk("hold_ready", 32'(in_ready), 0);
      chk("write_pending", 32'(exp_q.size()), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_ad", 32'({wa, wd}), 32'(e));
      end
      low_len = 0;
    end
  endtask

  // mode 0: in_valid always high, data 1..N; mode 1: every 3rd cycle; mode 2: random.
  task automatic load(input int mode, input int stop_addr, input int exp_cycles, output bit stopped);
    int s;
    int n;
    bit entered;
    stopped = 0;
    in_valid = 1'b0;
    accepted = 0;
    loading = 1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    s = cycle;
    chk("start_state", 32'({done, timeout, busy, ch_s2, cpu_n_clr, in_ready}), 32'b001001);
    for (int g = 0; g < 600; g++) begin
      if (accepted == PROG_LEN && exp_q.size() == 0 && low_len == 0) break;
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cycle % 3 == 0) : 1'($urandom_range(0, 2) != 0);
      in_data  = (mode == 0) ? 8'(accepted + 1) : 8'($urandom);
      n_hlt    = 1'($urandom);
      if (mode == 2) start = 1'($urandom_range(0, 15) == 0);
      if (in_valid && in_ready) begin
        last_push = {4'(accepted), in_data};
        exp_q.push_back(last_push);
        accepted++;
        just_xfer = 1;
      end
      cyc();
      start = 1'b0;
      if (stop_addr >= 0 && ch_s4 === 1'b0 && low_len == 1 && a == 4'(stop_addr)) begin
        stopped = 1;
        return;
      end
    end
    chk("load_complete", 32'(accepted == PROG_LEN && exp_q.size() == 0), 1);
    in_valid = 1'b1;
    in_data = 8'hEE;
    n = 0;
    entered = 0;
    for (int g = 0; g < 40; g++) begin
      n_hlt = 1'($urandom);
      cyc();
      if (cpu_n_clr === 1'b1) begin
        entered = 1;
        break;
      end
      chk("clear_sw", 32'({ch_s2, ch_s4, busy}), 32'b111);
      n++;
    end
    chk("run_entered", 32'(entered), 1);
    chk("clear_len", 32'(n), CLR_CYCLES);
    if (exp_cycles > 0) chk("load_cycles", 32'(cycle - s), 32'(exp_cycles));
    chk("run_entry", 32'({ch_s2, busy, done, timeout}), 32'b1100);
    in_valid = 1'b0;
    loading = 0;
  endtask

  // halt_at = RUN cycle on which n_hlt is low (0 = never).
  task automatic run_phase(input int halt_at);
    for (int k = 1; k <= RUN_TIMEOUT + 5; k++) begin
      n_hlt = (k == halt_at) ? 1'b0 : 1'b1;
      cyc();
      if (k == halt_at) begin
        chk("halt_state", 32'({done, timeout, busy, cpu_n_clr, ch_s2}), 32'b10011);
        n_hlt = 1'b1;
        return;
      end
      if (k == RUN_TIMEOUT) begin
        chk("timeout_state", 32'({done, timeout, busy, cpu_n_clr, ch_s2}), 32'b01000);
        return;
      end
      chk("running", 32'({done, timeout, busy, cpu_n_clr, ch_s2}), 32'b00111);
    end
    chk("run_budget", 0, 1);
  endtask

  initial begin
    bit st;

    // Reset values.
    n_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset", 32'({ch_s2, ch_s4, a, d, cpu_n_clr, in_ready, busy, done, timeout}),
        32'({1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    n_clr = 1'b1;
    in_valid = 1'b1;
    cyc();
    chk("idle_hold", 32'({busy, in_ready, ch_s4, cpu_n_clr, ch_s2}), 32'b00100);
    in_valid = 1'b0;

    // Back-to-back bytes 0x01..0x10, halt on RUN cycle 10.
    load(0, -1, PROG_LEN * (WE_CYCLES + 3) + CLR_CYCLES, st);
    run_phase(10);
    cyc();
    chk("done_hold", 32'({done, busy, ch_s2, cpu_n_clr}), 32'b1011);

    // Gapped input, no halt: run until the timeout.
    load(1, -1, 0, st);
    run_phase(0);
    cyc();
    chk("fault_hold", 32'({timeout, done, ch_s2, cpu_n_clr, busy}), 32'b10000);

    // Abort during the write of address 5.
    load(0, 5, 0, st);
    chk("abort_reached", 32'(st), 1);
    exp_q.delete();
    low_len = 0;
    just_xfer = 0;
    loading = 0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_state", 32'({ch_s4, busy, in_ready, cpu_n_clr, ch_s2, done, timeout}), 32'b1000000);

    // A byte offered together with abort is dropped.
    loading = 1;
    accepted = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("wait_ready", 32'(in_ready), 1);
    loading = 0;
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    cyc();
    abort = 1'b0;
    chk("abort_byte", 32'({in_ready, busy}), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_after_abort", 32'({in_ready, busy, ch_s4}), 32'b001);
    end
    in_valid = 1'b0;

    // Reload from address 0; halt coincides with the last timeout cycle.
    load(0, -1, PROG_LEN * (WE_CYCLES + 3) + CLR_CYCLES, st);
    run_phase(RUN_TIMEOUT);

    // Asynchronous reset in the middle of a write.
    load(1, 3, 0, st);
    chk("reset_reached", 32'(st), 1);
    #2;
    n_clr = 1'b0;
    #1;
    chk("async_reset", 32'({ch_s4, cpu_n_clr, a, busy, in_ready}), 32'({1'b1, 1'b0, 4'h0, 1'b0, 1'b0}));
    exp_q.delete();
    low_len = 0;
    just_xfer = 0;
    loading = 0;
    @(negedge clk);
    n_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      cyc();
      chk("idle_after_reset", 32'({busy, in_ready, ch_s4, cpu_n_clr, ch_s2, a}), 32'({5'b00100, 4'h0}));
    end
    in_valid = 1'b0;

    // Random gaps, random data, stray start pulses, early halt.
    load(2, -1, 0, st);
    run_phase(int'($urandom_range(1, 40)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sap1_program_loader.md
Name: sap1_program_loader

Overview:
Upstream stage of the SAP-1 top level. It replaces the manual front-panel switches (memory address, data byte, run/load and write switches) with a sequencer. The loader accepts a stream of program bytes over a valid/ready handshake and writes them into SAP-1 RAM at consecutive addresses. It then switches the CPU to execute mode, pulses the CPU clear, and monitors the halt line until the program finishes or times out.

Parameters:
PROG_LEN, 16, number of bytes written per load; legal range 1..16; bytes go to addresses 0..PROG_LEN-1.
WE_CYCLES, 2, number of cycles the write switch (ch_s4) is held low per byte; minimum 1.
CLR_CYCLES, 4, number of cycles cpu_n_clr is held low after the switch to execute mode; minimum 1.
RUN_TIMEOUT, 1023, maximum number of RUN cycles before timeout is flagged; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge; the CPU uses the same clock.
n_clr  in  1  asynchronous, active-low reset of the loader.
start  in  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or FAULT.
abort  in  1  synchronous abort; takes priority over all other inputs.
in_valid  in  1  program byte is available on in_data.
in_data  in  8  program byte.
in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid and in_ready are both high at a rising edge.
n_hlt  in  1  CPU halt line from the controller; low means halted.
ch_s2  out  1  CPU run/load switch: 0 = load, 1 = execute.
ch_s4  out  1  RAM write switch, active low: 0 = write.
a  out  4  RAM address during load.
d  out  8  RAM data during load.
cpu_n_clr  out  1  active-low clear driven to the CPU.
busy  out  1  high in every state except IDLE, DONE and FAULT.
done  out  1  CPU halted normally; stays high until the next start or abort.
timeout  out  1  RUN_TIMEOUT expired; stays high until the next start or abort.

Behaviour:
- All outputs are registered. Effects listed below appear one cycle after the triggering edge.
- Reset (n_clr low, asynchronous):
  - state = IDLE.
  - ch_s2 = 0, ch_s4 = 1, a = 0, d = 0, cpu_n_clr = 0.
  - in_ready = 0, busy = 0, done = 0, timeout = 0.
  - Internal counters = 0.
  - A reset mid-write forces ch_s4 = 1 immediately, so no partial write continues.
- IDLE:
  - Outputs ch_s2 = 0, ch_s4 = 1, cpu_n_clr = 0; the CPU is held in clear.
  - On start: clear the address counter to 0 and go to WAIT_BYTE.
- WAIT_BYTE:
  - in_ready = 1.
  - On a transfer: latch d = in_data and a = address counter, then go to SETUP.
- SETUP (1 cycle):
  - in_ready = 0, ch_s4 = 1. Address and data are stable before the write.
- WRITE (WE_CYCLES cycles):
  - ch_s4 = 0. a and d are held constant.
- HOLD (1 cycle):
  - ch_s4 = 1. a and d are held, giving hold time after the write.
  - Increment the address counter.
  - If the counter now equals PROG_LEN, go to CLEAR; otherwise go to WAIT_BYTE.
- Per-byte timing: with in_valid held high, one byte takes 1 + 1 + WE_CYCLES + 1 cycles, which is 5 cycles at the default. The minimum per-byte period is WE_CYCLES + 3.
- CLEAR (CLR_CYCLES cycles):
  - ch_s2 = 1, ch_s4 = 1, cpu_n_clr = 0.
  - n_hlt is ignored in this state.
  - Then go to RUN.
- RUN:
  - cpu_n_clr = 1, ch_s2 = 1.
  - n_hlt is sampled every cycle, and a cycle counter counts from 1.
  - If n_hlt is low: go to DONE, done = 1.
  - Otherwise, if RUN_TIMEOUT != 0 and the counter reaches RUN_TIMEOUT: go to FAULT, timeout = 1, cpu_n_clr = 0.
  - If both conditions occur in the same cycle, halt wins and the block goes to DONE.
- DONE:
  - ch_s2 = 1 and cpu_n_clr = 1, so the CPU output register stays visible.
  - start begins a new load and clears done.
- FAULT:
  - ch_s2 = 0 and cpu_n_clr = 0.
  - start begins a new load and clears timeout.
- start in any other state is ignored.
- abort in any state:
  - Next state is IDLE with ch_s4 = 1 and cpu_n_clr = 0.
  - done and timeout are cleared, and in_ready = 0.
  - A byte offered in the abort cycle is not accepted.
- Address arithmetic: the address counter is 5 bits wide so that it can hold the value 16. Output a is its low 4 bits and never wraps in legal use.
- in_ready is never high outside WAIT_BYTE. A byte is consumed only through a transfer.

Test Plan:
1. Reset then start, with in_valid held high and bytes 0x01..0x10: 16 writes occur. Each write has ch_s4 low for exactly 2 cycles with a = 0..15 and d = byte. CLEAR lasts 4 cycles, then RUN begins.
2. In RUN, drive n_hlt low on the 10th RUN cycle: the next cycle shows done = 1, busy = 0, cpu_n_clr = 1, ch_s2 = 1.
3. Hold n_hlt high with RUN_TIMEOUT = 1023: timeout = 1 after the 1023rd RUN cycle, together with cpu_n_clr = 0 and ch_s2 = 0.
4. Drive in_valid with gaps (high every 3rd cycle): each byte is written exactly once. in_ready is low from SETUP through HOLD, and no address is skipped.
5. Assert abort during WRITE of address 5: the next cycle shows ch_s4 = 1 and state IDLE. A subsequent start rewrites from address 0.
6. Assert n_clr low mid-WRITE, asynchronously between edges: ch_s4 = 1, cpu_n_clr = 0 and a = 0 take effect immediately; after release the block stays in IDLE until start.
